// File: rtl/order_quantity_arbiter.sv
// -----------------------------------------------------------------------------
// order_quantity_arbiter
//
// Shares one free-running, fully pipelined order_quantity datapath among
// NUM_REQ inventory requesters. A round-robin arbiter picks one requester per
// cycle and registers its inventory onto the datapath input. A tag pipeline
// travels alongside the datapath so that each order/filter result is steered
// back to the requester that issued it.
//
// Ports:
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_enable                1 = new grants allowed (in-flight work always drains)
//   i_req_valid             per-requester request valid
//   i_req_inventory         packed inventories, requester k at [k*DATA_W +: DATA_W]
//   o_req_ready             one-hot combinational grant
//   o_oq_inventory_state    registered inventory driven into the datapath
//   i_oq_order_out          datapath order result
//   i_oq_order_filter       datapath filter result
//   o_rsp_valid             one-hot single-cycle response strobe
//   o_rsp_order             registered order result
//   o_rsp_filter            registered filter result
//   o_inflight              issues accepted but not yet returned
//   o_busy                  o_inflight != 0
// -----------------------------------------------------------------------------
module order_quantity_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PIPE_LATENCY = 6,
    parameter int DATA_W       = 64,
    parameter int FILTER_W     = 33
) (
    input  logic                              i_clk,
    input  logic                              i_reset,
    input  logic                              i_enable,
    input  logic [NUM_REQ-1:0]                i_req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]         i_req_inventory,
    output logic [NUM_REQ-1:0]                o_req_ready,
    output logic [DATA_W-1:0]                 o_oq_inventory_state,
    input  logic [DATA_W-1:0]                 i_oq_order_out,
    input  logic [FILTER_W-1:0]               i_oq_order_filter,
    output logic [NUM_REQ-1:0]                o_rsp_valid,
    output logic [DATA_W-1:0]                 o_rsp_order,
    output logic [FILTER_W-1:0]               o_rsp_filter,
    output logic [$clog2(PIPE_LATENCY+2)-1:0] o_inflight,
    output logic                              o_busy
);

    localparam int IDX_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int INF_W      = $clog2(PIPE_LATENCY + 2);
    // Stage 0 lines up with the inventory register; the remaining
    // PIPE_LATENCY stages mirror the datapath, so the last stage is valid
    // exactly when the matching result sits on i_oq_*.
    localparam int TAG_STAGES = PIPE_LATENCY + 1;
    localparam int LAST       = TAG_STAGES - 1;

    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [INF_W-1:0]    inflight_q, inflight_d;
    logic [DATA_W-1:0]   invState_q;
    logic [TAG_STAGES-1:0] tagValid_q;
    logic [IDX_W-1:0]    tagIdx_q [TAG_STAGES];
    logic [NUM_REQ-1:0]  rspValid_q;
    logic [DATA_W-1:0]   rspOrder_q;
    logic [FILTER_W-1:0] rspFilter_q;

    logic [NUM_REQ-1:0]  grant;
    logic [IDX_W-1:0]    grantIdx;
    logic [IDX_W-1:0]    candIdx;
    logic                accept;
    logic [NUM_REQ-1:0]  rspOneHot;

    // Round-robin search starting at the pointer; the first valid requester
    // wins. Grants are suppressed while disabled or in reset, so accept is
    // simply "some grant was issued".
    always_comb begin
        grant    = '0;
        grantIdx = '0;
        candIdx  = '0;
        accept   = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            candIdx = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (i_enable && !i_reset && !accept && i_req_valid[candIdx]) begin
                accept          = 1'b1;
                grantIdx        = candIdx;
                grant[candIdx]  = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner; in-flight count nets accepts
    // against captured responses.
    always_comb begin
        ptr_d      = ptr_q;
        inflight_d = inflight_q;
        rspOneHot  = '0;
        if (accept) begin
            ptr_d = IDX_W'((int'(grantIdx) + 1) % NUM_REQ);
        end
        case ({accept, tagValid_q[LAST]})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase
        rspOneHot[tagIdx_q[LAST]] = 1'b1;
    end

    // Reset discards every tag, so results of pre-reset issues that still
    // emerge from the datapath are never captured.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ptr_q       <= '0;
            inflight_q  <= '0;
            invState_q  <= '0;
            tagValid_q  <= '0;
            rspValid_q  <= '0;
            rspOrder_q  <= '0;
            rspFilter_q <= '0;
            for (int s = 0; s < TAG_STAGES; s++) begin
                tagIdx_q[s] <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            inflight_q <= inflight_d;
            if (accept) begin
                invState_q <= i_req_inventory[int'(grantIdx)*DATA_W +: DATA_W];
            end
            tagValid_q  <= {tagValid_q[TAG_STAGES-2:0], accept};
            tagIdx_q[0] <= grantIdx;
            for (int s = 1; s < TAG_STAGES; s++) begin
                tagIdx_q[s] <= tagIdx_q[s-1];
            end
            if (tagValid_q[LAST]) begin
                rspValid_q  <= rspOneHot;
                rspOrder_q  <= i_oq_order_out;
                rspFilter_q <= i_oq_order_filter;
            end else begin
                rspValid_q  <= '0;
            end
        end
    end

    assign o_req_ready          = grant;
    assign o_oq_inventory_state = invState_q;
    assign o_rsp_valid          = rspValid_q;
    assign o_rsp_order          = rspOrder_q;
    assign o_rsp_filter         = rspFilter_q;
    assign o_inflight           = inflight_q;
    assign o_busy               = (inflight_q != '0);

endmodule

// File: doc/order_quantity_arbiter.md
Name: order_quantity_arbiter

Overview:
Shares one free-running order_quantity datapath among NUM_REQ inventory requesters, e.g. per-symbol quoting engines. It runs a round-robin grant, drives the datapath's inventory input and tags each issue with the requester index. A tag pipeline matched to the datapath latency routes each order_out/order_filter result back to the requester that issued it. The block sits between the per-symbol inventory trackers and the order_quantity unit.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
PIPE_LATENCY, 6, cycles from an o_oq_inventory_state change to the matching i_oq_* outputs
DATA_W, 64, inventory and order width
FILTER_W, 33, order filter width

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_enable  in  1  1 = grants allowed; 0 = no new issues, in-flight results still drain
i_req_valid  in  NUM_REQ  per-requester request valid
i_req_inventory  in  NUM_REQ*DATA_W  packed signed q1.34 inventory; requester k uses bits [k*DATA_W +: DATA_W]
o_req_ready  out  NUM_REQ  one-hot grant (combinational)
o_oq_inventory_state  out  DATA_W  registered inventory to the datapath
i_oq_order_out  in  DATA_W  datapath order output
i_oq_order_filter  in  FILTER_W  datapath filter output
o_rsp_valid  out  NUM_REQ  one-hot, 1-cycle response strobe
o_rsp_order  out  DATA_W  registered order result
o_rsp_filter  out  FILTER_W  registered filter result
o_inflight  out  $clog2(PIPE_LATENCY+2)  issues not yet returned
o_busy  out  1  o_inflight != 0

Behaviour:
- Reset values: o_oq_inventory_state=0, o_rsp_valid=0, o_rsp_order=0, o_rsp_filter=0, o_inflight=0, tag pipeline cleared, RR pointer=0.
- Arbitration: combinational, round-robin.
  - Search starts at the pointer and wraps modulo NUM_REQ.
  - First k with i_req_valid[k] gets o_req_ready[k]=1.
  - o_req_ready=0 when i_enable=0 or i_reset=1.
  - At most one grant per cycle.
- Accept: when i_req_valid[k] && o_req_ready[k] at a rising edge:
  - o_oq_inventory_state <= requester k's slice;
  - tag stage 0 <= {1, k};
  - pointer <= (k+1) mod NUM_REQ.
- No accept: o_oq_inventory_state holds its value and tag stage 0 valid <= 0. The datapath output is ignored for that slot.
- Tag pipeline: PIPE_LATENCY stages shift every cycle unconditionally. There is no backpressure; the datapath is fully pipelined.
- Response: when the last tag stage is valid with index k, at the next edge:
  - o_rsp_valid <= one-hot(k);
  - o_rsp_order <= i_oq_order_out;
  - o_rsp_filter <= i_oq_order_filter.
  - Otherwise o_rsp_valid <= 0 and the data registers hold.
- Latency: a response strobe appears exactly PIPE_LATENCY+1 cycles after the accept edge.
- Throughput: 1 issue per cycle sustained. Responses return in issue order.
- o_inflight:
  - +1 on accept, -1 on response capture.
  - Unchanged when both happen in the same cycle.
  - Never exceeds PIPE_LATENCY+1.
- i_enable falling mid-stream: in-flight results still return. The pointer holds.
- Reset mid-operation: all in-flight tags are discarded. No o_rsp_valid is emitted for pre-reset issues, even though the datapath still produces them. o_req_ready is 0 during the reset cycle.
- A requester dropping valid without a handshake is legal and has no side effects.
- NUM_REQ=1 degenerates to grant = valid & enable.

Test Plan:
- Single request: NUM_REQ=4, PIPE_LATENCY=6, requester 2 valid one cycle with inventory 64'h0000_0004_0000_0000, datapath model = registered +1 delay line -> ready[2]=1 that cycle; o_rsp_valid=4'b0100 exactly 7 cycles after accept with the model's result; o_inflight goes 1 then 0.
- All four requesters valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; response strobes in the same order, back-to-back; o_inflight plateaus at 7.
- Requesters 1 and 3 valid, pointer at 2 -> grant 3, then 1, then 3; no grant to an invalid requester.
- i_enable=0 while 3 issues are in flight -> no new ready; 3 responses still arrive; o_busy falls to 0 afterwards.
- Assert i_reset for 1 cycle with 4 issues in flight -> all outputs return to reset values; no o_rsp_valid for the next 10 cycles without new requests; o_oq_inventory_state=0.
- Accept and response in the same cycle (steady stream) -> o_inflight constant; o_rsp_order matches a scoreboard for 100 random inventories.
